// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit: a DEPTH-deep shift register of in-flight
// destination writes, youngest-producer selection per read port, and a stall counter.

module fwd_port #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3
) (
  input  logic [DEPTH-1:0]           vld,
  input  logic [DEPTH-1:0][AW-1:0]   rd,
  input  logic [DEPTH-1:0]           rdy,
  input  logic [DEPTH-1:0][XLEN-1:0] data,
  input  logic [AW-1:0]              addr,
  input  logic                       used,
  output logic                       flag,
  output logic [XLEN-1:0]            fdata,
  output logic                       hazard
);
  logic hit;

  // First match from entry 0 upward is the youngest producer; once found,
  // older entries are ignored even if they hold ready data.
  always_comb begin
    hit    = 1'b0;
    flag   = 1'b0;
    fdata  = '0;
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && used && vld[i] && rd[i] == addr) begin
        hit = 1'b1;
        if (rdy[i]) begin
          flag  = 1'b1;
          fdata = data[i];
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int NRD        = 2,
  parameter int LOAD_STAGE = 0,
  parameter int CNTW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                ex_valid,
  input  logic                ex_regwrite,
  input  logic [AW-1:0]       ex_rd,
  input  logic                ex_rdy,
  input  logic [XLEN-1:0]     ex_result,
  input  logic                fill_valid,
  input  logic [XLEN-1:0]     fill_data,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_used,
  output logic [NRD-1:0]      fwd_flag,
  output logic [NRD*XLEN-1:0] fwd_data,
  output logic                stall,
  output logic [CNTW-1:0]     stall_cnt
);
  logic [DEPTH-1:0]           vld_pipe;
  logic [DEPTH-1:0][AW-1:0]   rd_q;
  logic [DEPTH-1:0]           rdy_q;
  logic [DEPTH-1:0][XLEN-1:0] data_q;
  logic [NRD-1:0]             hazard;
  logic                       fill_hit;
  logic                       wr_qual;

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [XLEN-1:0] pdata;
      fwd_port #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_port (
        .vld   (vld_pipe),
        .rd    (rd_q),
        .rdy   (rdy_q),
        .data  (data_q),
        .addr  (rs_addr[k*AW +: AW]),
        .used  (rs_used[k]),
        .flag  (fwd_flag[k]),
        .fdata (pdata),
        .hazard(hazard[k])
      );
      assign fwd_data[k*XLEN +: XLEN] = pdata;
    end
  endgenerate

  assign stall    = (|hazard) && !hold;
  assign fill_hit = fill_valid && vld_pipe[LOAD_STAGE] && !rdy_q[LOAD_STAGE];
  assign wr_qual  = ex_valid && ex_regwrite && (ex_rd != '0) && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      rd_q      <= '0;
      rdy_q     <= '0;
      data_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != {CNTW{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (!hold) begin
        vld_pipe[0] <= wr_qual;
        rd_q[0]     <= ex_rd;
        rdy_q[0]    <= ex_rdy;
        data_q[0]   <= ex_result;
        for (int i = 1; i < DEPTH; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          rd_q[i]     <= rd_q[i-1];
          rdy_q[i]    <= rdy_q[i-1];
          data_q[i]   <= data_q[i-1];
        end
        // Filled entry is moving on this cycle, so the completion follows it.
        if (fill_hit) begin
          rdy_q[LOAD_STAGE+1]  <= 1'b1;
          data_q[LOAD_STAGE+1] <= fill_data;
        end
      end else if (fill_hit) begin
        rdy_q[LOAD_STAGE]  <= 1'b1;
        data_q[LOAD_STAGE] <= fill_data;
      end
    end
  end
endmodule
